// File: rtl/dsm_serial_tx.sv
// Serializes a WIDTH-bit word MSB first to a DSM-style shift register,
// framed by en and clocked by a divided sclk.
module dsm_serial_tx #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             sclk,
  output logic             sdata,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS     = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_end;

  // Next-state logic; outputs are derived from the next state so they register
  // in the same cycle the state changes.
  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sdata_d = sdata_q;
    div_end = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        div_d = 8'd0;
        if (start) begin
          state_d = SETUP;
          shreg_d = word << 1;
          sdata_d = word[WIDTH-1];
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (div_end) state_d = HIGH;
      end
      HIGH: begin
        if (div_end) begin
          state_d = LOW;
          bit_d   = bit_q + CNT_W'(1);
          // Data advances on the falling edge only while bits remain.
          if (bit_q != LAST_BIT) begin
            sdata_d = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
          end
        end
      end
      LOW: begin
        if (div_end) begin
          if (bit_q == BITS) begin
            state_d = FINISH;
            bit_d   = '0;
            shreg_d = '0;
            sdata_d = 1'b0;
          end else begin
            state_d = HIGH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) div_d = 8'd0;

    sclk_d = (state_d == HIGH);
    en_d   = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW);
    busy_d = en_d;
    done_d = (state_d == FINISH);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign en    = en_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_dsm_serial_tx.sv
// Scoreboard bench for dsm_serial_tx: two instances (CLK_DIV=2 and CLK_DIV=1)
// driven by directed and random stimulus, checked by a receiver-side monitor.
module tb_dsm_serial_tx;

  localparam int W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_a, start_a, rst_n_b, start_b;
  logic [W-1:0] word_a, word_b;
  logic         sclk_a, sdata_a, en_a, busy_a, done_a;
  logic         sclk_b, sdata_b, en_b, busy_b, done_b;

  dsm_serial_tx #(.WIDTH(W), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .word(word_a),
    .sclk(sclk_a), .sdata(sdata_a), .en(en_a), .busy(busy_a), .done(done_a));

  dsm_serial_tx #(.WIDTH(W), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .word(word_b),
    .sclk(sclk_b), .sdata(sdata_b), .en(en_b), .busy(busy_b), .done(done_b));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a frame accepted at edge t occupies edges up to t+L+1,
  // so the next start is accepted from edge t+L+2 (L = (2W+1)*CLK_DIV).
  int edge_n[2], free_at[2], last_acc[2], accepted[2], aborted[2];
  logic [W-1:0] exp_a[$], exp_b[$];

  // Receiver-side monitor state.
  bit   p_sclk[2], p_sdata[2], p_en[2], p_done[2], rst_seen[2], active[2];
  int   cyc[2], en_cnt[2], rises[2], last_rise[2], en_start[2], dones[2];
  logic [W-1:0] cur[2], rx[2];

  function automatic int div_of(input int id);
    return (id == 0) ? 2 : 1;
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s (dut %s): got %0d, expected %0d at %0t", name,
               "", act, exp, $time);
    end
  endtask

  task automatic cyc_drive(input int id, input logic rst, input logic st, input logic [W-1:0] w);
    int e, len;
    e   = edge_n[id];
    len = (2 * W + 1) * div_of(id);
    if (id == 0) begin rst_n_a = rst; start_a = st; word_a = w; end
    else         begin rst_n_b = rst; start_b = st; word_b = w; end
    if (!rst) begin
      if (e > last_acc[id] && e < free_at[id]) aborted[id]++;
      free_at[id] = e + 1;
    end else if (st && e >= free_at[id]) begin
      accepted[id]++;
      last_acc[id] = e;
      free_at[id]  = e + len + 2;
      if (id == 0) exp_a.push_back(w); else exp_b.push_back(w);
    end
    @(posedge clk);
    #1;
    edge_n[id]++;
  endtask

  task automatic idle(input int id);
    cyc_drive(id, 1'b1, 1'b0, W'($urandom));
  endtask

  task automatic wait_free(input int id);
    while (edge_n[id] < free_at[id] + 2) idle(id);
  endtask

  task automatic random_phase(input int id, input int n);
    for (int i = 0; i < n; i++)
      cyc_drive(id, ($urandom_range(0, 399) != 0), ($urandom_range(0, 7) == 0), W'($urandom));
  endtask

  task automatic seq_a();
    int t;
    for (int i = 0; i < 3; i++) cyc_drive(0, 1'b0, 1'b1, 9'h1C3);
    idle(0);
    // Basic frame
    cyc_drive(0, 1'b1, 1'b1, 9'h1A5);
    wait_free(0);
    // Starts during a frame are dropped
    cyc_drive(0, 1'b1, 1'b1, 9'h155);
    for (int k = 1; k <= 25; k++) cyc_drive(0, 1'b1, (k == 5 || k == 20), W'($urandom));
    wait_free(0);
    // Back-to-back: start in FINISH ignored, next IDLE accepted
    cyc_drive(0, 1'b1, 1'b1, W'($urandom));
    while (edge_n[0] < free_at[0] - 1) idle(0);
    cyc_drive(0, 1'b1, 1'b1, 9'h1FE);
    cyc_drive(0, 1'b1, 1'b1, 9'h001);
    wait_free(0);
    // Reset after the 4th sclk rise, then immediate restart
    t = edge_n[0];
    cyc_drive(0, 1'b1, 1'b1, 9'h16B);
    while (edge_n[0] < t + 7 * div_of(0) + 2) idle(0);
    cyc_drive(0, 1'b0, 1'b1, 9'h133);
    cyc_drive(0, 1'b1, 1'b1, 9'h0AA);
    wait_free(0);
    random_phase(0, 1500);
    wait_free(0);
  endtask

  task automatic seq_b();
    for (int i = 0; i < 3; i++) cyc_drive(1, 1'b0, 1'b1, 9'h0F0);
    cyc_drive(1, 1'b1, 1'b1, 9'h0FF);
    wait_free(1);
    random_phase(1, 1500);
    wait_free(1);
  endtask

  function automatic int q_size(input int id);
    return (id == 0) ? exp_a.size() : exp_b.size();
  endfunction

  task automatic mon(input int id, input bit sc, input bit sd, input bit e,
                     input bit b, input bit d, input bit rn);
    int dv;
    dv = div_of(id);
    cyc[id]++;
    if (rst_seen[id]) begin
      chk({sc, sd, e, b, d} == 5'b0, "reset_outputs_zero", int'({sc, sd, e, b, d}), 0);
      active[id] = 1'b0;
    end else begin
      chk(b == e, "busy_matches_en", int'(b), int'(e));
      if (!e) begin
        chk(!sc, "sclk_low_outside_en", int'(sc), 0);
        chk(!sd, "sdata_zero_outside_en", int'(sd), 0);
      end
      if (e && !p_en[id]) begin
        chk(!active[id], "no_frame_overlap", int'(active[id]), 0);
        chk(q_size(id) > 0, "frame_expected", q_size(id), 1);
        if (q_size(id) > 0) cur[id] = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
        else cur[id] = '0;
        chk(sd == cur[id][W-1], "first_bit_after_start", int'(sd), int'(cur[id][W-1]));
        active[id] = 1'b1; en_cnt[id] = 0; rises[id] = 0; rx[id] = '0; en_start[id] = cyc[id];
      end
      if (e) en_cnt[id]++;
      if (sc && !p_sclk[id]) begin
        chk(active[id], "sclk_rise_inside_frame", int'(active[id]), 1);
        chk(sd == p_sdata[id], "sdata_stable_at_rise", int'(sd), int'(p_sdata[id]));
        if (rises[id] == 0) chk(cyc[id] - en_start[id] == dv, "setup_length", cyc[id] - en_start[id], dv);
        else chk(cyc[id] - last_rise[id] == 2 * dv, "sclk_period", cyc[id] - last_rise[id], 2 * dv);
        if (rises[id] < W)
          chk(sd == cur[id][W-1-rises[id]], "bit_value", int'(sd), int'(cur[id][W-1-rises[id]]));
        rx[id] = {rx[id][W-2:0], sd};
        rises[id]++;
        last_rise[id] = cyc[id];
      end
      if (sc && p_sclk[id]) chk(sd == p_sdata[id], "sdata_hold_while_high", int'(sd), int'(p_sdata[id]));
      if (d) begin
        chk(!p_done[id], "done_single_cycle", int'(p_done[id]), 0);
        chk(active[id], "done_inside_frame", int'(active[id]), 1);
        chk(en_cnt[id] == (2 * W + 1) * dv, "en_high_cycles", en_cnt[id], (2 * W + 1) * dv);
        chk(rises[id] == W, "sclk_rise_count", rises[id], W);
        chk(rx[id] == cur[id], "received_word", int'(rx[id]), int'(cur[id]));
        active[id] = 1'b0;
        dones[id]++;
      end
    end
    p_sclk[id] = sc; p_sdata[id] = sd; p_en[id] = e; p_done[id] = d;
    rst_seen[id] = !rn;
  endtask

  always @(negedge clk) begin
    mon(0, sclk_a, sdata_a, en_a, busy_a, done_a, rst_n_a);
    mon(1, sclk_b, sdata_b, en_b, busy_b, done_b, rst_n_b);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      edge_n[i] = 0; free_at[i] = 0; last_acc[i] = -1; accepted[i] = 0; aborted[i] = 0;
      p_sclk[i] = 0; p_sdata[i] = 0; p_en[i] = 0; p_done[i] = 0; rst_seen[i] = 0;
      active[i] = 0; cyc[i] = 0; en_cnt[i] = 0; rises[i] = 0; last_rise[i] = 0;
      en_start[i] = 0; dones[i] = 0; cur[i] = '0; rx[i] = '0;
    end
    fork
      seq_a();
      seq_b();
    join
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(dones[i] == accepted[i] - aborted[i], "done_pulse_count", dones[i], accepted[i] - aborted[i]);
      chk(q_size(i) == 0, "all_frames_sent", q_size(i), 0);
    end
    chk(aborted[0] >= 1, "mid_frame_reset_aborted", aborted[0], 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
